// File: rtl/spectrum_capture_pkg.sv
// Shared definitions for the spectrum capture block: FSM encoding and
// width derivations used by the top level.
package spectrum_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Accumulator width: enough headroom to sum 2^avg_log2 full-scale bins.
    function automatic int acc_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    // Frame counter width; a single-frame capture still needs one bit.
    function automatic int frame_width(input int avg_log2);
        return (avg_log2 > 0) ? avg_log2 : 1;
    endfunction

endpackage

// File: rtl/spectrum_capture_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read
// port (1-cycle latency), contents not reset.
module spec_acc_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write on request; read address registered every cycle (read-old on collision).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/spectrum_capture.sv
// Spectrum capture: accumulates 2^AVG_LOG2 frames of magnitude bins
// (average or max-hold), writes the final frame's results to an external
// RAM port and reports the largest bin above PEAK_SKIP.
module spectrum_capture
    import spectrum_capture_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int AVG_LOG2  = 2,
    parameter int PEAK_SKIP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_max,
    input  logic [DATA_W-1:0] mag_data,
    input  logic              mag_valid,
    input  logic              mag_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_frame,
    output logic              fft_shutdown,
    output logic [ADDR_W-1:0] peak_addr,
    output logic [DATA_W-1:0] peak_val
);

    localparam int                 ACC_W      = acc_width(DATA_W, AVG_LOG2);
    localparam int                 FRAME_W    = frame_width(AVG_LOG2);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'((1 << AVG_LOG2) - 1);
    localparam logic [ADDR_W:0]    SKIP       = (ADDR_W + 1)'(PEAK_SKIP);

    state_t state, state_nxt;

    logic               mode_q;
    logic               draining;
    logic [ADDR_W-1:0]  bin_cnt;
    logic [FRAME_W-1:0] frame_cnt;

    logic start_ok, arm_sync, beat, bin_top, frame_err, frame_end, last_beat;

    logic              s1_valid, s1_first, s1_final, s1_last;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_mag;

    logic [ACC_W-1:0]  rd_data, fwd_data, acc_old, mag_ext, new_val;
    logic              fwd_q;
    logic [DATA_W-1:0] result;

    logic              wr_last;
    logic              pk_found;
    logic [ADDR_W-1:0] pk_addr;
    logic [DATA_W-1:0] pk_val;

    spec_acc_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ACC_W)
    ) u_acc_ram (
        .clk     (clk),
        .wr_en   (s1_valid),
        .wr_addr (s1_addr),
        .wr_data (new_val),
        .rd_addr (bin_cnt),
        .rd_data (rd_data)
    );

    assign busy         = (state == ST_ARM) || (state == ST_ACCUM);
    assign fft_shutdown = (state == ST_IDLE) || (state == ST_DONE);

    // Beat qualification and framing checks for the current input cycle.
    always_comb begin
        start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
        arm_sync  = (state == ST_ARM) && mag_valid && mag_last;
        beat      = (state == ST_ACCUM) && !draining && mag_valid;
        bin_top   = (bin_cnt == '1);
        frame_err = beat && (mag_last != bin_top);
        frame_end = beat && mag_last && bin_top;
        last_beat = frame_end && (frame_cnt == LAST_FRAME);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_ARM;
            ST_ARM:   if (arm_sync) state_nxt = ST_ACCUM;
            ST_ACCUM: begin
                if (frame_err) begin
                    state_nxt = ST_IDLE;
                end else if (wr_en && wr_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  if (start_ok) state_nxt = ST_ARM;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Bin/frame counters, mode latch and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            bin_cnt   <= '0;
            frame_cnt <= '0;
            draining  <= 1'b0;
            done      <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            if (start_ok) begin
                mode_q <= mode_max;
            end
            if (arm_sync) begin
                bin_cnt   <= '0;
                frame_cnt <= '0;
                draining  <= 1'b0;
            end else begin
                if (beat) begin
                    bin_cnt <= bin_cnt + ADDR_W'(1);
                end
                if (frame_end) begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
                if (last_beat) begin
                    draining <= 1'b1;
                end
            end
            done      <= (state == ST_ACCUM) && (state_nxt == ST_DONE);
            err_frame <= frame_err;
        end
    end

    // Read-modify-write combine; fwd covers a write and read of the same bin on one edge.
    always_comb begin
        acc_old = fwd_q ? fwd_data : rd_data;
        mag_ext = ACC_W'(s1_mag);
        if (s1_first) begin
            new_val = mag_ext;
        end else if (mode_q) begin
            new_val = (acc_old > mag_ext) ? acc_old : mag_ext;
        end else begin
            new_val = acc_old + mag_ext;
        end
        result = mode_q ? DATA_W'(new_val) : DATA_W'(new_val >> AVG_LOG2);
    end

    // Stage 1: beat captured while the RAM read is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_final <= 1'b0;
            s1_last  <= 1'b0;
            s1_addr  <= '0;
            s1_mag   <= '0;
            fwd_q    <= 1'b0;
            fwd_data <= '0;
        end else begin
            s1_valid <= beat && !frame_err;
            if (beat) begin
                s1_addr  <= bin_cnt;
                s1_mag   <= mag_data;
                s1_first <= (frame_cnt == '0);
                s1_final <= (frame_cnt == LAST_FRAME);
                s1_last  <= last_beat;
            end
            fwd_q    <= s1_valid && (s1_addr == bin_cnt);
            fwd_data <= new_val;
        end
    end

    // Stage 2: result write port, running peak, peak outputs latched at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            wr_last   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            pk_found  <= 1'b0;
            pk_addr   <= '0;
            pk_val    <= '0;
            peak_addr <= '0;
            peak_val  <= '0;
        end else begin
            wr_en   <= s1_valid && s1_final && !frame_err;
            wr_last <= s1_valid && s1_last && !frame_err;
            if (s1_valid && s1_final) begin
                wr_addr <= s1_addr;
                wr_data <= result;
            end
            if (arm_sync) begin
                pk_found <= 1'b0;
            end else if (s1_valid && s1_final && !frame_err && ({1'b0, s1_addr} >= SKIP)
                         && (!pk_found || (result > pk_val))) begin
                pk_found <= 1'b1;
                pk_addr  <= s1_addr;
                pk_val   <= result;
            end
            if (wr_en && wr_last) begin
                peak_addr <= pk_addr;
                peak_val  <= pk_val;
            end
        end
    end

endmodule

// File: doc/spectrum_capture.md
SPECTRUM_CAPTURE -- requirements
Module: spectrum_capture

Interface
REQ-001 Parameter DATA_W, default 16, magnitude width.
REQ-002 Parameter ADDR_W, default 12, frame length N = 2^ADDR_W bins.
REQ-003 Parameter AVG_LOG2, default 2, frames per capture F = 2^AVG_LOG2, legal range 0..4.
REQ-004 Parameter PEAK_SKIP, default 2, low bins excluded from peak search.
REQ-005 clk  in  1  single clock, all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle capture request.
REQ-008 mode_max  in  1  0 = average, 1 = max-hold; sampled on accepted start.
REQ-009 mag_data  in  DATA_W  magnitude bin, unsigned.
REQ-010 mag_valid / mag_last  in  1 / 1  bin strobe / final bin of frame.
REQ-011 wr_en, wr_addr[ADDR_W], wr_data[DATA_W]  out  result write port to external RAM.
REQ-012 busy, done, err_frame  out  1 each  status; done and err_frame are one-cycle pulses.
REQ-013 fft_shutdown  out  1  high whenever state is IDLE or DONE.
REQ-014 peak_addr[ADDR_W], peak_val[DATA_W]  out  largest result bin, valid from done.

Function
REQ-015 States: IDLE, ARM, ACCUM, DONE.
REQ-016 IDLE/DONE + start -> ARM; start in ARM/ACCUM ignored.
REQ-017 ARM discards beats; mag_valid&mag_last -> ACCUM, bin counter = 0, frame counter = 0.
REQ-018 ACCUM: each mag_valid beat is bin b = bin counter; counter increments, wraps to 0 on mag_last.
REQ-019 Internal accumulator width ACC_W = DATA_W+AVG_LOG2; frame 0 writes mag_data, later frames write acc+mag_data (average) or max(acc,mag_data) (max-hold).
REQ-020 Read-modify-write: accumulator read issued in beat cycle, write 1 cycle later; back-to-back beats at full rate.
REQ-021 Final frame (frame counter = F-1): wr_en pulses 2 cycles after each beat, wr_addr = b, wr_data = (acc+mag)>>AVG_LOG2 (average) or max value (max-hold); no output writes in earlier frames.
REQ-022 Peak tracker on final-frame results with b >= PEAK_SKIP; strict greater-than update, so ties keep lowest bin.
REQ-023 Frame end: mag_last with b = N-1 increments frame counter; after frame F-1, enter DONE one cycle after the last wr_en; done pulses on entry.
REQ-024 Framing error: mag_last with b != N-1, or beat at b = N-1 without mag_last -> err_frame pulse, return to IDLE, outputs of partial capture undefined in RAM, peak outputs unchanged.
REQ-025 busy = state is ARM or ACCUM.
REQ-026 AVG_LOG2 = 0 degenerates to single-frame pass-through with 2-cycle latency.

Reset
REQ-027 Asynchronous reset: state IDLE; counters, wr_en, wr_addr, wr_data, busy, done, err_frame, peak_addr, peak_val = 0; fft_shutdown = 1.
REQ-028 Accumulator RAM contents not reset; frame 0 overwrite makes this safe.
REQ-029 Reset mid-capture aborts without done or err_frame pulse.

Structure
REQ-030 Shared package holds state encoding and ACC_W derivation function.
REQ-031 Sub-module spec_acc_ram: inferred simple dual-port RAM, depth 2^ADDR_W, width ACC_W, 1-cycle read latency, no reset.

Verification
REQ-032 ADDR_W=4, AVG_LOG2=0, ramp mag=b*10 -> 16 writes, wr_data=b*10, peak_addr=15, peak_val=150, done once.
REQ-033 ADDR_W=4, AVG_LOG2=2, average; four frames of value 4,8,12,16 at bin 5, zero elsewhere -> wr_data[5]=10, peak_addr=5.
REQ-034 Same, max-hold, bin 7 values 3,90,20,40 -> wr_data[7]=90, peak_val=90.
REQ-035 start mid-frame (bin 9 in flight) -> beats discarded until mag_last; first written frame begins at next bin 0.
REQ-036 mag_last at bin 10 of 16 -> err_frame pulse, state IDLE, fft_shutdown=1, no done.
REQ-037 Bins 0,1 = 1000, bin 3 = 500, PEAK_SKIP=2 -> peak_addr=3; asynchronous reset in frame 2 -> all outputs at reset values within same cycle.
